// File: rtl/track_dump_ctrl.sv
// rtl/track_dump_ctrl.sv - epoch-aligned accumulator snapshot, differencing and dump stream
module track_dump_ctrl #(
    parameter int NUM_CH    = 6,
    parameter int ACC_WIDTH = 32,
    parameter int EPOCH_DLY = 2,
    parameter int IDX_WIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_en,
    input  logic                        i_epoch,
    input  logic [7:0]                  i_int_len,
    input  logic [NUM_CH*ACC_WIDTH-1:0] i_acc_bus,
    output logic [NUM_CH*ACC_WIDTH-1:0] o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [IDX_WIDTH-1:0]        o_dump_idx,
    output logic                        o_overrun,
    input  logic                        i_ovr_clr,
    output logic [1:0]                  o_state
);
    localparam int BUS_W = NUM_CH * ACC_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 in_idle, in_align, in_run;
    logic                 epoch_d;
    logic [7:0]           len_q, ep_cnt_q, len_smp;
    logic                 pend_q;
    logic [BUS_W-1:0]     base_q, snap_q, diff;
    logic [BUS_W-1:0]     data_q;
    logic                 valid_q, ovr_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic                 align_ev, dump_ev, load;

    assign len_smp = (i_int_len == 8'd0) ? 8'd1 : i_int_len;

    // Delays i_epoch to line up with the accumulator pipeline; emptied while idle.
    generate
        if (EPOCH_DLY == 0) begin : g_no_dly
            assign epoch_d = i_epoch;
        end else begin : g_dly
            logic [EPOCH_DLY-1:0] dly_q;
            always_ff @(posedge i_clk) begin
                if (!i_rstn || in_idle) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= (dly_q << 1) | EPOCH_DLY'(i_epoch);
                end
            end
            assign epoch_d = dly_q[EPOCH_DLY-1];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_en) state_d = ALIGN;
            ALIGN:   if (!i_en) state_d = IDLE; else if (epoch_d) state_d = RUN;
            RUN:     if (!i_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_idle  = (state_q == IDLE);
        in_align = (state_q == ALIGN);
        in_run   = (state_q == RUN);
        o_state  = state_q;
    end

    assign align_ev = in_align & i_en & epoch_d;
    assign dump_ev  = in_run & i_en & epoch_d & ((ep_cnt_q + 8'd1) == len_q);
    // A dump still in the subtract stage is dropped if the channel is disabled.
    assign load     = pend_q & in_run & i_en;

    always_ff @(posedge i_clk) begin
        if (!i_rstn || !i_en) begin
            ep_cnt_q <= 8'd0;
            len_q    <= 8'd1;
            pend_q   <= 1'b0;
        end else begin
            pend_q <= dump_ev;
            if (align_ev || dump_ev) begin
                ep_cnt_q <= 8'd0;
                len_q    <= len_smp;
            end else if (in_run && epoch_d) begin
                ep_cnt_q <= ep_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            base_q <= '0;
            snap_q <= '0;
        end else begin
            if (align_ev) begin
                base_q <= i_acc_bus;
            end else if (load) begin
                base_q <= snap_q;
            end
            if (dump_ev) begin
                snap_q <= i_acc_bus;
            end
        end
    end

    // Modular difference: accumulator wrap between snapshots cancels out.
    always_comb begin
        diff = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            diff[ch*ACC_WIDTH +: ACC_WIDTH] = snap_q[ch*ACC_WIDTH +: ACC_WIDTH]
                                            - base_q[ch*ACC_WIDTH +: ACC_WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (load) begin
                data_q  <= diff;
                valid_q <= 1'b1;
                idx_q   <= idx_q + IDX_WIDTH'(1);
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
            if (load && valid_q && !i_ready) begin
                ovr_q <= 1'b1;
            end else if (i_ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_dump_idx = idx_q;
    assign o_overrun  = ovr_q;
endmodule

// File: tb/tb_track_dump_ctrl.sv
// tb/tb_track_dump_ctrl.sv - scoreboard bench for track_dump_ctrl
module tb_track_dump_ctrl;
    localparam int NCH = 6;
    localparam int AW  = 32;
    localparam int BW  = NCH * AW;
    localparam int IW  = 16;

    logic          clk = 1'b0;
    logic          rstn, en, epoch, ready, ovr_clr;
    logic [7:0]    int_len;
    logic [BW-1:0] acc, o_data;
    logic          o_valid, o_overrun;
    logic [IW-1:0] o_idx;
    logic [1:0]    o_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [BW-1:0] data;
        logic [IW-1:0] idx;
    } exp_t;
    exp_t sb[$];

    logic [BW-1:0] m_base;
    logic [7:0]    m_len, m_cnt;
    bit            m_aligned;
    logic [IW-1:0] m_idx;

    always #5 clk = ~clk;

    track_dump_ctrl #(.NUM_CH(NCH), .ACC_WIDTH(AW), .EPOCH_DLY(2), .IDX_WIDTH(IW)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_epoch(epoch), .i_int_len(int_len),
        .i_acc_bus(acc), .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
        .o_dump_idx(o_idx), .o_overrun(o_overrun), .i_ovr_clr(ovr_clr), .o_state(o_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd_bus();
        logic [BW-1:0] b;
        for (int c = 0; c < NCH; c++) b[c*AW +: AW] = $urandom;
        return b;
    endfunction

    // Reference behaviour of one epoch, pushed to the scoreboard when it completes a dump.
    task automatic model_epoch(input logic [BW-1:0] a);
        exp_t e;
        if (!m_aligned) begin
            m_aligned = 1'b1;
            m_base    = a;
            m_cnt     = 8'd0;
            m_len     = (int_len == 8'd0) ? 8'd1 : int_len;
        end else if (m_cnt + 8'd1 == m_len) begin
            for (int c = 0; c < NCH; c++) e.data[c*AW +: AW] = a[c*AW +: AW] - m_base[c*AW +: AW];
            m_idx  = m_idx + 16'd1;
            e.idx  = m_idx;
            sb.push_back(e);
            m_base = a;
            m_cnt  = 8'd0;
            m_len  = (int_len == 8'd0) ? 8'd1 : int_len;
        end else begin
            m_cnt = m_cnt + 8'd1;
        end
    endtask

    task automatic pulse_only(input logic [BW-1:0] a, input int gap);
        acc   = a;
        epoch = 1'b1;
        model_epoch(a);
        tick();
        epoch = 1'b0;
        for (int i = 1; i < gap; i++) tick();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_valid && n < 40) begin
            tick();
            n++;
        end
        chk("valid_wait", o_valid, 1);
    endtask

    task automatic check_front(input bit consume);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        wait_valid();
        chk("dump_data", o_data, sb[0].data);
        chk("dump_idx", o_idx, sb[0].idx);
        if (consume) begin
            void'(sb.pop_front());
            ready = 1'b1;
            tick();
            ready = 1'b0;
            chk("valid_drop", o_valid, 0);
        end
    endtask

    task automatic pulse(input logic [BW-1:0] a, input int gap);
        pulse_only(a, gap);
        if (sb.size() > 0) check_front(1);
        else chk("no_dump", o_valid, 0);
    endtask

    initial begin
        logic [BW-1:0] a, b;
        rstn = 1'b0; en = 1'b0; epoch = 1'b0; ready = 1'b0; ovr_clr = 1'b0;
        int_len = 8'd1; acc = '0;
        m_base = '0; m_len = 8'd1; m_cnt = 8'd0; m_aligned = 1'b0; m_idx = '0;
        tick(); tick();
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_idx", o_idx, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_state", o_state, 0);
        rstn = 1'b1;
        tick();
        chk("idle_hold", o_state, 0);
        en = 1'b1;
        tick();
        chk("align_state", o_state, 1);

        // Basic dump with latency check
        a = '0; a[31:0] = 32'd100;
        pulse(a, 6);
        chk("run_state", o_state, 2);
        a[31:0] = 32'd350;
        pulse_only(a, 3);
        chk("valid_early", o_valid, 0);
        tick();
        chk("valid_lat", o_valid, 1);
        chk("basic_ch0", o_data[31:0], 250);
        chk("basic_idx", o_idx, 1);
        check_front(1);

        // Accumulator wrap in both directions on channel 2
        a[95:64] = 32'hFFFF_FFF0;
        pulse(a, 6);
        a[95:64] = 32'h0000_0010;
        pulse_only(a, 3);
        wait_valid();
        chk("wrap_up", o_data[95:64], 32'h0000_0020);
        check_front(1);
        a[95:64] = 32'h0000_0000;
        pulse_only(a, 3);
        wait_valid();
        chk("wrap_neg", o_data[95:64], 32'hFFFF_FFF0);
        check_front(1);

        // Integration lengths: 4, 0 (as 1), and a mid-period change
        int_len = 8'd4;
        for (int i = 0; i < 9; i++) pulse(rnd_bus(), 20);
        int_len = 8'd0;
        for (int i = 0; i < 6; i++) pulse(rnd_bus(), 6);
        int_len = 8'd3;
        pulse(rnd_bus(), 6);
        pulse(rnd_bus(), 6);
        int_len = 8'd2;
        for (int i = 0; i < 4; i++) pulse(rnd_bus(), 6);
        int_len = 8'd1;
        pulse(rnd_bus(), 6);
        pulse(rnd_bus(), 6);

        // Backpressure across two dumps
        pulse_only(rnd_bus(), 6);
        pulse_only(rnd_bus(), 6);
        wait_valid();
        if (sb.size() == 2) begin
            chk("ovr_data", o_data, sb[1].data);
            chk("ovr_idx", o_idx, sb[1].idx);
        end else chk("ovr_sb_depth", sb.size(), 2);
        chk("ovr_set", o_overrun, 1);
        sb.delete();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("ovr_valid_drop", o_valid, 0);
        chk("ovr_sticky", o_overrun, 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr", o_overrun, 0);

        // Load in the same cycle as a transfer
        pulse_only(rnd_bus(), 6);
        check_front(0);
        pulse_only(rnd_bus(), 3);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("coinc_valid", o_valid, 1);
        chk("coinc_ovr", o_overrun, 0);
        void'(sb.pop_front());
        check_front(1);

        // Disable the cycle after a dump event
        pulse_only(rnd_bus(), 3);
        en = 1'b0;
        tick();
        chk("dis_state", o_state, 0);
        chk("dis_valid", o_valid, 0);
        tick(); tick(); tick();
        chk("dis_discard", o_valid, 0);
        void'(sb.pop_back());
        m_aligned = 1'b0;
        m_idx = m_idx - 16'd1;
        en = 1'b1;
        tick();
        chk("reen_align", o_state, 1);
        pulse(rnd_bus(), 6);
        pulse(rnd_bus(), 6);

        // Reset in the middle of RUN with a pending overrun
        pulse_only(rnd_bus(), 6);
        pulse_only(rnd_bus(), 6);
        chk("pre_rst_ovr", o_overrun, 1);
        rstn = 1'b0;
        tick();
        chk("mrst_data", o_data, 0);
        chk("mrst_valid", o_valid, 0);
        chk("mrst_idx", o_idx, 0);
        chk("mrst_ovr", o_overrun, 0);
        chk("mrst_state", o_state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/track_dump_ctrl.md
Name: track_dump_ctrl

Overview:
- Downstream of the per-correlator track accumulators. Those accumulators free-run and are never cleared in operation.
- Snapshots all correlator accumulators (I/Q × E/P/L) on code-epoch boundaries, delayed to match the accumulator pipeline.
- Forms per-integration-period sums by modular subtraction of successive snapshots.
- Presents each dump on a valid/ready stream to the tracking-loop processor, with overrun detection.

Parameters:
- NUM_CH, 6, number of accumulator channels (IE, IP, IL, QE, QP, QL order, channel 0 at LSBs)
- ACC_WIDTH, 32, width of each accumulator and each output sum
- EPOCH_DLY, 2, cycles i_epoch is delayed before snapshot (accumulator pipeline depth)
- IDX_WIDTH, 16, width of dump index counter

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, synchronous, active-low; clock i_clk
- i_en  in  1  channel enable; low forces IDLE
- i_epoch  in  1  single-cycle pulse at C/A code rollover
- i_int_len  in  8  epochs per dump; 0 treated as 1
- i_acc_bus  in  NUM_CH*ACC_WIDTH  free-running accumulator values
- o_data  out  NUM_CH*ACC_WIDTH  per-channel integration sums
- o_valid  out  1  o_data valid
- i_ready  in  1  consumer accept
- o_dump_idx  out  IDX_WIDTH  index of dump on o_data
- o_overrun  out  1  sticky: unconsumed dump overwritten
- i_ovr_clr  in  1  clears o_overrun
- o_state  out  2  FSM state, for debug

Behaviour:
- Reset (i_rstn low at clock edge):
  - o_data=0, o_valid=0, o_dump_idx=0, o_overrun=0, o_state=IDLE.
  - Baseline, snapshot, epoch counter and delay line all cleared.
- Epoch delay:
  - EPOCH_DLY-stage shift register produces epoch_d, which is i_epoch delayed EPOCH_DLY cycles.
  - EPOCH_DLY=0 means epoch_d=i_epoch.
- FSM states: IDLE(0), ALIGN(1), RUN(2).
  - IDLE: held while i_en=0. i_en=1 → ALIGN. Delay line is flushed while in IDLE.
  - ALIGN: first epoch_d → baseline<=i_acc_bus, len_q<=max(i_int_len,1), ep_cnt<=0, → RUN. No output is produced.
  - RUN: each epoch_d increments ep_cnt.
    - When ep_cnt+1==len_q: dump event. snap<=i_acc_bus, ep_cnt<=0, len_q<=max(i_int_len,1) re-sampled.
    - Otherwise ep_cnt<=ep_cnt+1.
  - i_en=0 in ALIGN or RUN → IDLE next cycle.
    - Counters are cleared and any dump in the subtract pipeline is discarded.
    - A pending o_valid/o_data is retained until consumed.
- Dump pipeline (cycle E = dump-event cycle):
  - Edge ending E: snap captured.
  - Edge ending E+1: o_data[ch] <= snap[ch] − baseline[ch] (mod 2^ACC_WIDTH), baseline<=snap, o_valid<=1, o_dump_idx increments (wraps at 2^IDX_WIDTH).
  - o_valid is first seen high in cycle E+2. Total latency from i_epoch = EPOCH_DLY+2 cycles.
  - The first dump after ALIGN carries o_dump_idx=1. The index resets to 0 only on reset.
- Handshake:
  - Transfer occurs when o_valid & i_ready. o_valid then drops next cycle unless a new load happens in that same cycle.
  - o_data is stable while o_valid=1 and no load occurs.
- Simultaneous load and transfer in one cycle: new data loaded, o_valid stays 1, no overrun.
- Load while o_valid=1 & i_ready=0: data overwritten, o_overrun<=1.
- o_overrun clear rules:
  - i_ovr_clr clears o_overrun.
  - If i_ovr_clr coincides with a new overrun, set wins.
- Arithmetic:
  - Subtraction is unsigned modular. The result is interpreted as two's-complement signed, so accumulator wrap-around is transparent.
  - No saturation.
- i_epoch pulses arriving faster than the pipeline (spacing < 2 cycles) are not supported.

Test Plan:
- Basic dump:
  - Stimulus: int_len=1, EPOCH_DLY=2; channel 0 accumulator =100 at first epoch_d, =350 at second.
  - Required: o_data[0]=250, o_dump_idx=1, o_valid high 4 cycles after the second i_epoch; ALIGN epoch produces no output.
- Wrap-around:
  - Stimulus: channel 2 baseline 0xFFFFFFF0, snapshot 0x00000010.
  - Required: o_data[2]=0x00000020.
  - Stimulus: baseline 0x10, snapshot 0x0.
  - Required: 0xFFFFFFF0 (−16).
- Integration length:
  - Stimulus: int_len=4 with epochs every 20 cycles.
  - Required: dumps every 4th epoch.
  - Stimulus: int_len=0.
  - Required: dump every epoch.
  - Stimulus: change int_len mid-period.
  - Required: new value applies only after the next dump.
- Backpressure and overrun:
  - Stimulus: i_ready=0 across two dumps.
  - Required: second dump overwrites o_data, o_dump_idx=2, o_overrun=1. o_overrun stays 1 after i_ready=1 until i_ovr_clr.
  - Stimulus: load coinciding with a transfer.
  - Required: o_valid stays 1, no overrun.
- Disable/reset mid-run:
  - Stimulus: i_en=0 one cycle after a dump event.
  - Required: that dump is discarded, state IDLE. Re-enable → ALIGN with a fresh baseline.
  - Stimulus: i_rstn=0 mid-RUN.
  - Required: all outputs 0 on the next edge.
